// File: rtl/uart_pkg.sv
// Shared constants and idle-detector state encoding for the UART receive controller.
package uart_pkg;

  localparam int BYTE_W        = 8;
  localparam int DIV_W_DEFAULT = 16;
  localparam int TICKS_PER_BIT = 16;

  typedef enum logic {
    IDLE_DISARMED = 1'b0,
    IDLE_ARMED    = 1'b1
  } idle_state_e;

  // Number of oversample ticks that make up the quiet-line window.
  function automatic int idle_limit(input int idle_bits);
    return idle_bits * TICKS_PER_BIT;
  endfunction

endpackage

// File: rtl/uart_byte_fifo.sv
// First-word fall-through byte FIFO; a push into a full FIFO is only taken when a pop frees a slot.
module uart_byte_fifo
  import uart_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              push,
  input  logic [BYTE_W-1:0] push_data,
  input  logic              pop,
  output logic [BYTE_W-1:0] head_data,
  output logic              not_empty,
  output logic [CW-1:0]     count,
  output logic              drop
);

  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [BYTE_W-1:0] mem_q [DEPTH];
  logic [BYTE_W-1:0] mem_d [DEPTH];
  logic              empty;
  logic              full;
  logic              pop_ok;
  logic              push_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the head is masked whenever the FIFO is empty.
  always_ff @(posedge clk_in) begin
    mem_q <= mem_d;
  end

  assign head_data = empty ? '0 : mem_q[rd_ptr_q];
  assign not_empty = !empty;
  assign count     = count_q;
  assign drop      = push && full && !pop_ok;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: 16x oversample tick divider, receive byte FIFO with sticky
// overrun flag, and an idle-line detector that fires once after a quiet period.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter  int FIFO_DEPTH = 16,
  parameter  int DIV_W      = DIV_W_DEFAULT,
  parameter  int IDLE_BITS  = 4,
  localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              cfg_en,
  input  logic [DIV_W-1:0]  cfg_div,
  output logic              rx_en,
  input  logic              rx_finish,
  input  logic [BYTE_W-1:0] rx_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [BYTE_W-1:0] m_data,
  output logic [CNT_W-1:0]  fifo_count,
  output logic              overrun,
  input  logic              ovr_clr,
  output logic              idle_timeout
);

  localparam int IDLE_LIMIT = idle_limit(IDLE_BITS);
  localparam int IW         = $clog2(IDLE_LIMIT + 1);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             rx_en_q, rx_en_d;
  logic             overrun_q, overrun_d;
  idle_state_e      state_q, state_d;
  logic [IW-1:0]    idle_cnt_q, idle_cnt_d;
  logic             idle_timeout_q, idle_timeout_d;
  logic             fifo_drop;
  logic             fifo_not_empty;

  uart_byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_in    (clk_in),
    .rst       (rst),
    .push      (rx_finish),
    .push_data (rx_data),
    .pop       (m_ready),
    .head_data (m_data),
    .not_empty (fifo_not_empty),
    .count     (fifo_count),
    .drop      (fifo_drop)
  );

  assign m_valid = fifo_not_empty;

  // The tick is registered, so a terminal count seen in one cycle shows up on rx_en the next;
  // this gives exactly cfg_div+1 cycles from enable (or reset release) to the first tick.
  always_comb begin
    div_cnt_d = '0;
    rx_en_d   = 1'b0;
    if (cfg_en) begin
      if (div_cnt_q >= cfg_div) begin
        rx_en_d = 1'b1;
      end else begin
        div_cnt_d = div_cnt_q + 1'b1;
      end
    end
  end

  // A fresh drop outranks a clear so no overrun event is ever lost.
  always_comb begin
    overrun_d = overrun_q;
    if (fifo_drop) begin
      overrun_d = 1'b1;
    end else if (ovr_clr) begin
      overrun_d = 1'b0;
    end
  end

  // Any received byte (kept or dropped) counts as line activity and restarts the quiet window.
  always_comb begin
    state_d        = state_q;
    idle_cnt_d     = idle_cnt_q;
    idle_timeout_d = 1'b0;
    if (!cfg_en) begin
      state_d    = IDLE_DISARMED;
      idle_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE_DISARMED: begin
          if (rx_finish) begin
            state_d    = IDLE_ARMED;
            idle_cnt_d = '0;
          end
        end
        IDLE_ARMED: begin
          if (rx_finish) begin
            idle_cnt_d = '0;
          end else if (rx_en_q) begin
            if (idle_cnt_q == IW'(IDLE_LIMIT - 1)) begin
              idle_timeout_d = 1'b1;
              state_d        = IDLE_DISARMED;
              idle_cnt_d     = '0;
            end else begin
              idle_cnt_d = idle_cnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_d    = IDLE_DISARMED;
          idle_cnt_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      div_cnt_q      <= '0;
      rx_en_q        <= 1'b0;
      overrun_q      <= 1'b0;
      state_q        <= IDLE_DISARMED;
      idle_cnt_q     <= '0;
      idle_timeout_q <= 1'b0;
    end else begin
      div_cnt_q      <= div_cnt_d;
      rx_en_q        <= rx_en_d;
      overrun_q      <= overrun_d;
      state_q        <= state_d;
      idle_cnt_q     <= idle_cnt_d;
      idle_timeout_q <= idle_timeout_d;
    end
  end

  assign rx_en        = rx_en_q;
  assign overrun      = overrun_q;
  assign idle_timeout = idle_timeout_q;

endmodule
